// File: rtl/compare_arbiter_pkg.sv
// Shared types and defaults for the compare arbiter.
// Holds the FSM state encoding and the default sizing constants.
package compare_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_IDX_W   = $clog2(DEF_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RSP
    } cmp_arb_state_t;

endpackage

// File: rtl/compare_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. Returns a one-hot grant and its encoded index.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[IW'(j)]) begin
                any_o          = 1'b1;
                gnt_o[IW'(j)]  = 1'b1;
                idx_o          = IW'(j);
            end
        end
    end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one signed/unsigned magnitude comparator.
// IDLE grants and captures, CMP evaluates, RSP strobes the result.
module compare_arbiter
    import compare_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]       req_signed_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic                     rsp_agtb_o,
    output logic                     busy_o
);

    localparam int IW = $clog2(NUM_REQ);

    cmp_arb_state_t   state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             agtb_q, agtb_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        agtb_d      = agtb_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_agtb_o  = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = pick_gnt;
                if (pick_any) begin
                    idx_d   = pick_idx;
                    state_d = CMP;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == IW'(i)) begin
                            a_d   = req_a_i[i*WIDTH +: WIDTH];
                            b_d   = req_b_i[i*WIDTH +: WIDTH];
                            sgn_d = req_signed_i[i];
                        end
                    end
                end
            end
            CMP: begin
                busy_o  = 1'b1;
                agtb_d  = sgn_q ? ($signed(a_q) > $signed(b_q))
                                : (a_q > b_q);
                state_d = RSP;
            end
            RSP: begin
                busy_o              = 1'b1;
                rsp_valid_o[idx_q]  = 1'b1;
                rsp_agtb_o          = agtb_q;
                rr_ptr_d            = (idx_q == IW'(NUM_REQ - 1))
                                      ? '0 : idx_q + IW'(1);
                state_d             = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            agtb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            agtb_q   <= agtb_d;
        end
    end

endmodule

// File: tb/tb_compare_arbiter.sv
// Scoreboard bench for compare_arbiter: a cycle-level reference model
// predicts grants and responses; a monitor matches the response strobes.
module tb_compare_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic [N-1:0]   vld = '0;
    logic [N-1:0]   sgn = '0;
    logic [N*W-1:0] ra = '0;
    logic [N*W-1:0] rb = '0;
    logic [N-1:0]   ready;
    logic [N-1:0]   rsp_valid;
    logic           rsp_agtb;
    logic           busy;

    compare_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (vld),
        .req_ready_o  (ready),
        .req_a_i      (ra),
        .req_b_i      (rb),
        .req_signed_i (sgn),
        .rsp_valid_o  (rsp_valid),
        .rsp_agtb_o   (rsp_agtb),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit gt;
        int due;
    } exp_t;

    exp_t   q[$];
    int     n_tests = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     m_ptr = 0;
    int     m_busy_left = 0;
    logic [N-1:0] gnt_last = '0;
    bit     rand_en = 0;
    bit     all_en = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: value of the operand as a number, then plain comparison.
    function automatic bit ref_gt(logic [W-1:0] a, logic [W-1:0] b, logic s);
        int va;
        int vb;
        va = int'(a);
        vb = int'(b);
        if (s && va >= (1 << (W - 1))) va = va - (1 << W);
        if (s && vb >= (1 << (W - 1))) vb = vb - (1 << W);
        return va > vb;
    endfunction

    function automatic int ref_pick(logic [N-1:0] v, int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: predicts grant, busy and enqueues expected responses.
    initial forever begin
        logic [N-1:0] eg;
        int w;
        @(negedge clk);
        eg = '0;
        if (!rst_ni) begin
            m_ptr = 0;
            m_busy_left = 0;
            q.delete();
            chk("rst_ready", 32'(ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_agtb", 32'(rsp_agtb), 0);
            chk("rst_busy", 32'(busy), 0);
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            chk("busy_hi", 32'(busy), 1);
            chk("ready_lo", 32'(ready), 0);
        end else begin
            chk("busy_lo", 32'(busy), 0);
            w = ref_pick(vld, m_ptr);
            if (w >= 0) begin
                eg[w] = 1'b1;
                q.push_back('{idx: w,
                              gt: ref_gt(ra[w*W +: W], rb[w*W +: W], sgn[w]),
                              due: cyc + 2});
                m_busy_left = 2;
                m_ptr = (w + 1) % N;
            end
            chk("grant", 32'(ready), 32'(eg));
        end
        gnt_last = eg;
    end

    // Monitor: consumes expected responses when the DUT strobes.
    initial forever begin
        exp_t e;
        logic [N-1:0] ev;
        @(negedge clk);
        if (rst_ni) begin
            if (rsp_valid != '0) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    e = q.pop_front();
                    ev = '0;
                    ev[e.idx] = 1'b1;
                    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
                    chk("rsp_agtb", 32'(rsp_agtb), 32'(e.gt));
                    chk("rsp_latency", 32'(cyc), 32'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("rsp_missing", 32'(rsp_valid), 32'(1 << e.idx));
            end
        end
    end

    function automatic logic [W-1:0] pool();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 8'h00;
            1: v = 8'h7F;
            2: v = 8'h80;
            3: v = 8'hFF;
            4: v = 8'h01;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic set_req(int r, logic [W-1:0] a, logic [W-1:0] b, logic s);
        ra[r*W +: W] = a;
        rb[r*W +: W] = b;
        sgn[r] = s;
        vld[r] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (gnt_last[r]) begin
                vld[r] = 1'b0;
                ra[r*W +: W] = W'($urandom);
                rb[r*W +: W] = W'($urandom);
                sgn[r] = 1'($urandom);
            end
        end
        for (int r = 0; r < N; r++) begin
            if (rand_en) begin
                if (!vld[r]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(r, pool(), pool(), 1'($urandom));
                end else if (!gnt_last[r] && $urandom_range(0, 19) == 0) begin
                    vld[r] = 1'b0;
                end
            end
            if (all_en && !vld[r])
                set_req(r, pool(), pool(), 1'($urandom));
        end
    endtask

    task automatic wait_grant(int r);
        bit done;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            if (!vld[r]) done = 1;
        end
        if (!done) chk("grant_timeout", 32'(r), 32'hFFFF_FFFF);
    endtask

    task automatic one(int r, logic [W-1:0] a, logic [W-1:0] b, logic s);
        set_req(r, a, b, s);
        wait_grant(r);
        repeat (3) step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        repeat (2) step();

        one(0, 8'h0F, 8'hFF, 1'b1);
        one(0, 8'h0F, 8'hFF, 1'b0);
        one(0, 8'h80, 8'h80, 1'b1);
        one(0, 8'h80, 8'h80, 1'b0);
        one(0, 8'h80, 8'h7F, 1'b1);
        one(0, 8'h80, 8'h7F, 1'b0);

        all_en = 1;
        repeat (16) step();
        all_en = 0;
        vld = '0;
        repeat (4) step();

        set_req(2, 8'h10, 8'h20, 1'b0);
        wait_grant(2);
        set_req(0, 8'hF0, 8'h05, 1'b1);
        set_req(3, 8'hF0, 8'h05, 1'b0);
        wait_grant(3);
        wait_grant(0);
        repeat (4) step();

        set_req(1, 8'h55, 8'h11, 1'b0);
        wait_grant(1);
        rst_ni = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        repeat (2) step();
        rst_ni = 1'b1;
        set_req(1, 8'h01, 8'h02, 1'b0);
        set_req(3, 8'h02, 8'h01, 1'b0);
        wait_grant(1);
        wait_grant(3);
        repeat (4) step();

        rand_en = 1;
        repeat (400) step();
        rand_en = 0;
        vld = '0;
        repeat (6) step();
        chk("queue_drained", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/compare_arbiter.md
# compare_arbiter

Shares a single signed/unsigned magnitude comparator between `NUM_REQ` requesters. Each requester uses a valid/ready handshake to submit an operand pair and a mode bit, and receives a one-cycle "a greater than b" response. A round-robin scheduler picks the winner. A 3-state FSM then sequences capture, compare and respond, which bounds the comparator to one operation at a time. The block sits between the requesting datapath units and the comparison resource.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `WIDTH`, 8: operand width in bits.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  one-hot grant; the handshake completes when valid and ready are both high on an edge.
- `req_a_i`  in  NUM_REQ×WIDTH  operand a per requester.
- `req_b_i`  in  NUM_REQ×WIDTH  operand b per requester.
- `req_signed_i`  in  NUM_REQ  per requester: 1 = two's-complement compare, 0 = unsigned.
- `rsp_valid_o`  out  NUM_REQ  one-hot response strobe, high for one cycle.
- `rsp_agtb_o`  out  1  result, meaningful only while any `rsp_valid_o` bit is high.
- `busy_o`  out  1  high in CMP and RSP.

## Operation
FSM states: IDLE, CMP, RSP. Reset state is IDLE.

IDLE:
- `req_ready_o` is driven combinationally as the round-robin grant over `req_valid_i`. The search starts at `rr_ptr` and wraps modulo `NUM_REQ`.
- If any valid bit is high: capture the winner's a, b, mode and index into registers, then go to CMP.
- Otherwise stay in IDLE with `req_ready_o` = 0.

CMP:
- Compute `agtb` from the captured operands.
  - mode 1: signed compare over the full WIDTH.
  - mode 0: unsigned compare.
- Register the result. Equal operands give 0.
- Go to RSP.

RSP:
- Assert `rsp_valid_o[winner]` and `rsp_agtb_o` for one cycle.
- Set `rr_ptr` = (winner+1) mod `NUM_REQ`.
- Go to IDLE.

Rules:
- `req_ready_o` is 0 in CMP and RSP, so at most one grant is outstanding.
- Requesters hold valid, a, b and mode stable until granted. Operand changes after the grant have no effect.
- Responses have no backpressure. The requester must sample the response in the strobe cycle.
- Valid may drop without a grant. A request withdrawn while in IDLE is simply not granted.
- A request from the same requester in the RSP cycle is not seen until the next IDLE cycle.

## Timing
- Reset values: state = IDLE, `rr_ptr` = 0, `req_ready_o` = 0, `rsp_valid_o` = 0, `rsp_agtb_o` = 0, `busy_o` = 0, captured registers = 0.
- Latency: if the grant edge is cycle T, CMP is T+1 and the response strobe is visible in cycle T+2.
- Throughput: one comparison per 3 cycles under continuous load.
- With all requesters continuously valid, grant order is 0,1,…,NUM_REQ-1,0,…
- Pointer wrap: after winner `NUM_REQ`-1, `rr_ptr` becomes 0.
- Reset asserted in CMP or RSP aborts immediately:
  - `rsp_valid_o` is forced to 0 asynchronously.
  - No response is produced for the in-flight request.
  - `rr_ptr` returns to 0.
- Sign/width rule: the mode applies only to the captured requester. An MSB-set operand in unsigned mode is the larger value.

## Structure
- A shared package holds:
  - the state enum `cmp_arb_state_t` (IDLE, CMP, RSP);
  - the default `WIDTH` and `NUM_REQ` constants;
  - a `$clog2`-based index width constant.
- One sub-module: `rr_priority_picker`. It is purely combinational: request vector plus pointer in, one-hot grant out plus encoded index. It is reusable by other arbiters.
- The compare operation is inline in the CMP-state register update. No separate comparator instance is used.

## Test plan
- Requester 0, signed=1, a=0x0F, b=0xFF. Expect grant at T and `rsp_valid_o`=0001 at T+2 with `rsp_agtb_o`=1 (15 > -1).
- Same operands with signed=0. Expect `rsp_agtb_o`=0 (15 < 255).
- a=b=0x80 in both modes. Expect `rsp_agtb_o`=0. Also a=0x80, b=0x7F: signed gives 0, unsigned gives 1.
- All four requesters continuously valid from reset. Expect grants in order 0,1,2,3,0, spaced 3 cycles apart, and `busy_o` high in the two cycles after each grant.
- Requester 2 granted, then only requesters 0 and 3 valid. Expect next grant 3, then 0 (pointer wrap).
- Grant requester 1, then assert `rst_ni`=0 during CMP. Expect no `rsp_valid_o` pulse, all outputs at reset values, and after release the first grant follows round-robin from index 0.
